// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ frame sources.
// Optional macro UART_ARB_ID_HDR_EN prefixes each frame with a grant_id header word.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int W_IN          = 16,
    parameter int BITS_PER_WORD = 8,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0][W_IN-1:0]  s_data,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [BITS_PER_WORD-1:0]      m_data,
    input  logic                          m_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    if (NUM_REQ < 1) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be at least 1");
    end

    if ((W_IN % BITS_PER_WORD) != 0 || W_IN < BITS_PER_WORD) begin : g_bad_width
        $error("uart_tx_arbiter: W_IN must be a multiple of BITS_PER_WORD");
    end

`ifdef UART_ARB_ID_HDR_EN
    if (ID_W > BITS_PER_WORD) begin : g_bad_id_w
        $error("uart_tx_arbiter: grant_id does not fit in one header word");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HDR
    } state_t;
`else
    typedef enum logic {
        IDLE,
        SEND
    } state_t;
`endif

    state_t state_q, state_d;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             m_valid_q, m_valid_d;
    logic             busy_q, busy_d;

    logic [BITS_PER_WORD-1:0]                m_data_q, m_data_d;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] buf_q, buf_d;

    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            take;

    // Rotating priority search: first valid requester starting at ptr.
    always_comb begin
        win   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && s_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is pending,
    // so a requester cannot lose a frame to a reset edge.
    always_comb begin
        s_ready = '0;
        if (!rst && state_q == IDLE && |s_valid) begin
            s_ready[win] = 1'b1;
        end
    end

    assign take = |(s_valid & s_ready);

    // Next-state and datapath for the frame serialiser.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    buf_d     = s_data[win];
                    grant_d   = win;
                    ptr_d     = ID_W'((int'(win) + 1) % NUM_REQ);
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    m_valid_d = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
                    state_d   = HDR;
                    m_data_d  = BITS_PER_WORD'(win);
`else
                    state_d   = SEND;
                    m_data_d  = s_data[win][BITS_PER_WORD-1:0];
`endif
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            HDR: begin
                if (m_ready) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    m_data_d = buf_q[0];
                end
            end
`endif
            SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        m_valid_d = 1'b0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        m_data_d = buf_q[idx_q + 1'b1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, word order, backpressure
// and reset for uart_tx_arbiter (header sequence when UART_ARB_ID_HDR_EN is set).
module tb_uart_tx_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       s_valid = '0;
    logic [3:0][15:0] s_data = '0;
    logic [3:0]       s_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_ready = 1'b0;
    logic [1:0]       grant_id;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .W_IN         (16),
        .BITS_PER_WORD(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .grant_id(grant_id),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] mv,
                             input logic [31:0] md, input logic [31:0] gid,
                             input logic [31:0] bz);
        check({tag, "_m_valid"}, 32'(m_valid), mv);
        check({tag, "_m_data"}, 32'(m_data), md);
        check({tag, "_grant_id"}, 32'(grant_id), gid);
        check({tag, "_busy"}, 32'(busy), bz);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;

        // Reset held with every requester asking
        rst       = 1'b1;
        m_ready   = 1'b1;
        s_valid   = 4'hF;
        s_data[0] = 16'hA0B0;
        s_data[1] = 16'hA1B1;
        s_data[2] = 16'hA2B2;
        s_data[3] = 16'hA3B3;
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 0);
        check_out("rst", 0, 0, 0, 0);

`ifndef UART_ARB_ID_HDR_EN
        rst = 1'b0;
        #1;
        check("rst_first_grant", 32'(s_ready), 'b0001);
        tick();
        check_out("rst_f0_w0", 1, 'hB0, 0, 1);
        s_valid = '0;
        tick();
        check_out("rst_f0_w1", 1, 'hA0, 0, 1);
        tick();
        check("rst_f0_end_m_valid", 32'(m_valid), 0);
        check("rst_f0_end_busy", 32'(busy), 0);

        // Single frame from requester 1, valid held to show the ready pulse
        s_data[1] = 16'hBEEF;
        s_valid   = 4'b0010;
        #1;
        check("single_ready", 32'(s_ready), 'b0010);
        tick();
        check("single_ready_w0", 32'(s_ready), 0);
        check_out("single_w0", 1, 'hEF, 1, 1);
        tick();
        check("single_ready_w1", 32'(s_ready), 0);
        check_out("single_w1", 1, 'hBE, 1, 1);
        s_valid = '0;
        tick();
        check("single_end_m_valid", 32'(m_valid), 0);
        check("single_end_busy", 32'(busy), 0);
        check("single_end_grant", 32'(grant_id), 1);

        // Round robin from a fresh pointer with everyone requesting
        rst     = 1'b1;
        s_valid = '0;
        tick();
        tick();
        rst       = 1'b0;
        s_data[0] = 16'h1100;
        s_data[1] = 16'h3322;
        s_data[2] = 16'h5544;
        s_data[3] = 16'h7766;
        s_valid   = 4'hF;
        for (int f = 0; f < 5; f++) begin
            e = f % 4;
            #1;
            check("rr_ready", 32'(s_ready), 1 << e);
            tick();
            check_out("rr_w0", 1, 32'(s_data[e][7:0]), 32'(e), 1);
            tick();
            check_out("rr_w1", 1, 32'(s_data[e][15:8]), 32'(e), 1);
            tick();
            check("rr_gap", 32'(m_valid), 0);
        end
        s_valid = '0;

        // Backpressure on requester 2
        s_data[2] = 16'h1234;
        s_valid   = 4'b0100;
        m_ready   = 1'b0;
        #1;
        check("bp_ready", 32'(s_ready), 'b0100);
        tick();
        s_valid = '0;
        check_out("bp_w0", 1, 'h34, 2, 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("bp_hold_data", 32'(m_data), 'h34);
            check("bp_hold_valid", 32'(m_valid), 1);
        end
        m_ready = 1'b1;
        tick();
        check_out("bp_w1", 1, 'h12, 2, 1);
        tick();
        check("bp_end_m_valid", 32'(m_valid), 0);
        check("bp_end_busy", 32'(busy), 0);

        // Reset while the first word is being accepted
        s_data[1] = 16'hBEEF;
        s_valid   = 4'b0010;
        tick();
        s_valid = '0;
        check_out("mid_w0", 1, 'hEF, 1, 1);
        rst = 1'b1;
        tick();
        check_out("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_quiet_valid", 32'(m_valid), 0);
            check("mid_quiet_data", 32'(m_data), 0);
        end
        s_data[3] = 16'h5A5A;
        s_valid   = 4'b1010;
        #1;
        check("mid_ptr_cleared", 32'(s_ready), 'b0010);
        tick();
        s_valid = '0;
        check_out("mid_next_w0", 1, 'hEF, 1, 1);
        tick();
        check_out("mid_next_w1", 1, 'hBE, 1, 1);
        tick();
        check("mid_next_end", 32'(busy), 0);
`else
        // Header word carries the granted index
        rst       = 1'b0;
        s_valid   = '0;
        tick();
        s_data[2] = 16'h1234;
        s_valid   = 4'b0100;
        #1;
        check("hdr_ready", 32'(s_ready), 'b0100);
        tick();
        s_valid = '0;
        check_out("hdr_h", 1, 'h02, 2, 1);
        tick();
        check_out("hdr_w0", 1, 'h34, 2, 1);
        tick();
        check_out("hdr_w1", 1, 'h12, 2, 1);
        tick();
        check("hdr_end_m_valid", 32'(m_valid), 0);
        check("hdr_end_busy", 32'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
